oric_ps2_keymatrix: RTL and testbench
=====================================

// Module: oric_ps2_keymatrix
// PURPOSE
//  Converts hps_io ps2_key events into the Oric 8x8 keyboard matrix and answers telestrat scans.
//  Sits between hps_io ps2_key and the telestrat core.
//  The VIA drives PB[2:0] as the row and the PSG drives IOA as the active-low column mask; the block returns the PB3 sense bit.
//  Also generates the NMI (front-panel reset button) pulse from a dedicated key.
// PARAMETERS
//  NMI_SCANCODE   8'h07   non-extended PS/2 code (F12) that fires nmi_req
//  NMI_PULSE_LEN  16      nmi_req high time in clk_sys cycles (>=1)
//  CLR_SCANCODE   8'h7E   non-extended code (Scroll Lock) that releases every matrix key
// PORTS
//  clk_sys     in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  ps2_key     in   11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//  row_sel     in   3   VIA PB[2:0] row select
//  col_mask_n  in   8   PSG IOA; a 0 bit selects that column
//  key_sense   out  1   PB3: 1 = any pressed key in row_sel and a selected column
//  nmi_req     out  1   active-high NMI pulse to the telestrat core
//  matrix_dbg  out  64  flattened matrix, {row7..row0}, bit = row*8+col
// BEHAVIOUR
//  Reset values:
//   - All outputs 0, matrix all released, FSM in IDLE, pending buffer empty.
//   - strobe_q loads ps2_key[10], so no event fires on reset release.
//  Event detect:
//   - evt = ps2_key[10] ^ strobe_q, with strobe_q registered every cycle.
//   - On evt, {pressed, ext, code} is captured.
//  FSM IDLE -> LOOKUP -> UPDATE -> IDLE:
//   - IDLE: on evt or pending valid, issue ROM address {ext, code} and go to LOOKUP. The pending buffer has priority over a new event.
//   - LOOKUP: registered ROM data {valid, row[2:0], col[2:0]} becomes available.
//   - UPDATE: if valid, set matrix[row][col] = pressed, then return to IDLE.
//  Latency: evt seen at cycle N -> matrix bit changes at the N+3 edge -> key_sense reflects it at N+4.
//  Overlap: an evt arriving in LOOKUP or UPDATE is stored in a 1-deep pending buffer.
//   - A second evt while pending is full overwrites it (newest wins).
//   - The dropped-event condition is not flagged.
//  Special codes (ext=0), handled in UPDATE ahead of the table:
//   - NMI_SCANCODE press: load a counter with NMI_PULSE_LEN. nmi_req = (counter != 0).
//   - NMI_SCANCODE press while the counter is running restarts it. Release is ignored.
//   - CLR_SCANCODE press: clear all 64 matrix bits in that cycle. Release is ignored.
//  Unmapped codes (valid=0) change nothing.
//  Press of an already-pressed key and release of a released key are idempotent.
//  Both PS/2 shifts map to their own Oric matrix positions; no shift synthesis is done.
//  key_sense is registered: key_sense <= |(matrix[row_sel] & ~col_mask_n).
//   - col_mask_n = 8'hFF gives 0 regardless of the matrix.
//  Reset mid-operation: async reset aborts the FSM, discards pending, clears matrix and nmi counter.
// STRUCTURE
//  Package oric_kbd_pkg holds:
//   - typedef kbd_state_t {IDLE, LOOKUP, UPDATE}
//   - typedef keymap_t {logic valid; logic [2:0] row; logic [2:0] col;}
//   - localparams ROWS=8, COLS=8
//  Sub-module oric_keymap_rom: 512x7 synchronous ROM, address {ext, code}, 1-cycle read, contents from the pkg table.
//  Top block: edge detect, pending buffer, FSM, matrix regs, nmi counter, sense register.
// TESTING
//  1) Press 'A' (code 8'h1C, table row 6 col 5), row_sel=6, col_mask_n=8'hDF -> key_sense=1 at N+4; col_mask_n=8'hFF -> 0.
//  2) Press then release 8'h1C on consecutive strobe toggles 1 cycle apart -> pending used; final matrix_dbg bit 53 = 0, never lost.
//  3) Press F12 (8'h07) -> nmi_req high for exactly 16 cycles; second press at cycle 10 -> high until 10+16 after it.
//  4) Press 5 mapped keys, then Scroll Lock 8'h7E -> matrix_dbg = 64'h0 after UPDATE.
//  5) Extended 8'h75 vs plain 8'h75 -> distinct table entries; an unmapped extended code leaves matrix unchanged.
//  6) Assert reset during LOOKUP with pending full -> all outputs 0; release reset with ps2_key[10]=1 -> no spurious event.

Source files
------------

// File: rtl/oric_kbd_pkg.sv
// Shared types and the PS/2 set-2 to Oric keyboard matrix table.
// Table column numbering puts matrix bit row*8+col in the Oric scan order.
package oric_kbd_pkg;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned KEYS   = ROWS * COLS;
  localparam int unsigned ADDR_W = 9;

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} kbd_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } keymap_t;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

  function automatic keymap_t km(input int unsigned r, input int unsigned c);
    keymap_t m;
    m.valid = 1'b1;
    m.row   = 3'(r);
    m.col   = 3'(c);
    return m;
  endfunction

  // Address is {ext, code}; anything not listed is unmapped.
  function automatic keymap_t keymap_lookup(input logic [ADDR_W-1:0] addr);
    keymap_t m;
    m = '0;
    case (addr)
      9'h026: m = km(0, 7);  9'h022: m = km(0, 6);  9'h016: m = km(0, 5);
      9'h02A: m = km(0, 3);  9'h02E: m = km(0, 2);  9'h031: m = km(0, 1);
      9'h03D: m = km(0, 0);
      9'h023: m = km(1, 7);  9'h015: m = km(1, 6);  9'h076: m = km(1, 5);
      9'h02B: m = km(1, 3);  9'h02D: m = km(1, 2);  9'h02C: m = km(1, 1);
      9'h03B: m = km(1, 0);
      9'h021: m = km(2, 7);  9'h01E: m = km(2, 6);  9'h01A: m = km(2, 5);
      9'h014: m = km(2, 4);  9'h025: m = km(2, 3);  9'h032: m = km(2, 2);
      9'h036: m = km(2, 1);  9'h03A: m = km(2, 0);
      9'h052: m = km(3, 7);  9'h05D: m = km(3, 6);  9'h04E: m = km(3, 3);
      9'h04C: m = km(3, 2);  9'h046: m = km(3, 1);  9'h042: m = km(3, 0);
      9'h174: m = km(4, 7);  9'h172: m = km(4, 6);  9'h16B: m = km(4, 5);
      9'h012: m = km(4, 4);  9'h175: m = km(4, 3);  9'h049: m = km(4, 2);
      9'h041: m = km(4, 1);  9'h029: m = km(4, 0);
      9'h054: m = km(5, 7);  9'h05B: m = km(5, 6);  9'h066: m = km(5, 5);
      9'h011: m = km(5, 4);  9'h04D: m = km(5, 3);  9'h044: m = km(5, 2);
      9'h043: m = km(5, 1);  9'h03C: m = km(5, 0);
      9'h01D: m = km(6, 7);  9'h01B: m = km(6, 6);  9'h01C: m = km(6, 5);
      9'h024: m = km(6, 3);  9'h034: m = km(6, 2);  9'h033: m = km(6, 1);
      9'h035: m = km(6, 0);
      9'h055: m = km(7, 7);  9'h05A: m = km(7, 5);  9'h15A: m = km(7, 5);
      9'h059: m = km(7, 4);  9'h04A: m = km(7, 3);  9'h045: m = km(7, 2);
      9'h04B: m = km(7, 1);  9'h03E: m = km(7, 0);  9'h075: m = km(7, 0);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/oric_keymap_rom.sv
// Synchronous keymap ROM: one-cycle registered read, output held while en_i is low.
module oric_keymap_rom
  import oric_kbd_pkg::*;
(
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output keymap_t           data_o
);

  keymap_t data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) data_q <= keymap_lookup(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/oric_ps2_keymatrix.sv
// hps_io ps2_key events -> Oric 8x8 keyboard matrix, row/column scan sense and NMI button pulse.
module oric_ps2_keymatrix
  import oric_kbd_pkg::*;
#(
  parameter logic [7:0]  NMI_SCANCODE  = 8'h07,
  parameter int unsigned NMI_PULSE_LEN = 16,
  parameter logic [7:0]  CLR_SCANCODE  = 8'h7E
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [10:0]     ps2_key,
  input  logic [2:0]      row_sel,
  input  logic [7:0]      col_mask_n,
  output logic            key_sense,
  output logic            nmi_req,
  output logic [KEYS-1:0] matrix_dbg
);

  localparam int unsigned CNT_W = $clog2(NMI_PULSE_LEN + 1);

  logic            strobe_q;
  logic            evt_c;
  kbd_evt_t        evt_pl;
  kbd_evt_t        sel_c;
  kbd_evt_t        pend_q;
  logic            pend_vld_q;
  kbd_evt_t        cur_q;
  kbd_state_t      state_q;
  keymap_t         map;
  logic [KEYS-1:0] matrix_q;
  logic            is_nmi_c;
  logic            is_clr_c;
  logic            nmi_load_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            nmi_q;
  logic            sense_q;

  // Tracks the strobe even while reset is held, so reset release never looks like a toggle.
  always_ff @(posedge clk_sys) begin
    strobe_q <= ps2_key[10];
  end

  assign evt_c  = ps2_key[10] ^ strobe_q;
  assign evt_pl = kbd_evt_t'(ps2_key[9:0]);
  assign sel_c  = pend_vld_q ? pend_q : evt_pl;

  oric_keymap_rom u_rom (
    .clk_i  (clk_sys),
    .en_i   (state_q == IDLE),
    .addr_i ({sel_c.ext, sel_c.code}),
    .data_o (map)
  );

  assign is_nmi_c = !cur_q.ext && (cur_q.code == NMI_SCANCODE);
  assign is_clr_c = !cur_q.ext && (cur_q.code == CLR_SCANCODE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cur_q      <= '0;
      matrix_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_vld_q || evt_c) begin
            cur_q   <= sel_c;
            state_q <= LOOKUP;
          end
          // A new event arriving while the pending one is consumed takes its place.
          if (pend_vld_q) begin
            pend_vld_q <= evt_c;
            if (evt_c) pend_q <= evt_pl;
          end
        end
        LOOKUP: state_q <= UPDATE;
        UPDATE: begin
          if (is_clr_c) begin
            if (cur_q.pressed) matrix_q <= '0;
          end else if (!is_nmi_c && map.valid) begin
            matrix_q[{map.row, map.col}] <= cur_q.pressed;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if ((state_q != IDLE) && evt_c) begin
        pend_q     <= evt_pl;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign nmi_load_c = (state_q == UPDATE) && is_nmi_c && cur_q.pressed;

  always_comb begin
    cnt_d = cnt_q;
    if (nmi_load_c)          cnt_d = CNT_W'(NMI_PULSE_LEN);
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      nmi_q   <= 1'b0;
      sense_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      nmi_q   <= (cnt_d != '0);
      sense_q <= |(matrix_q[{row_sel, 3'b000} +: COLS] & ~col_mask_n);
    end
  end

  assign key_sense  = sense_q;
  assign nmi_req    = nmi_q;
  assign matrix_dbg = matrix_q;

endmodule

// File: tb/tb_oric_ps2_keymatrix.sv
// Directed bench for oric_ps2_keymatrix with hand-computed matrix, sense and NMI expectations.
module tb_oric_ps2_keymatrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [2:0]  row_sel;
  logic [7:0]  col_mask_n;
  logic        key_sense;
  logic        nmi_req;
  logic [63:0] matrix_dbg;

  int n_checks = 0;
  int n_errors = 0;

  oric_ps2_keymatrix dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .row_sel    (row_sel),
    .col_mask_n (col_mask_n),
    .key_sense  (key_sense),
    .nmi_req    (nmi_req),
    .matrix_dbg (matrix_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic pr, input logic ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
  endtask

  initial begin
    reset      = 1'b1;
    ps2_key    = '0;
    row_sel    = 3'd6;
    col_mask_n = 8'hFF;
    tick(3);
    check("rst_sense", 64'(key_sense), 64'd0);
    check("rst_nmi", 64'(nmi_req), 64'd0);
    check("rst_matrix", matrix_dbg, 64'h0);
    reset = 1'b0;
    tick(3);
    check("rst_release_idle", matrix_dbg, 64'h0);

    // Press 'A' -> row 6 col 5, bit 53; matrix at edge 3, sense at edge 4
    col_mask_n = 8'hDF;
    send(1'b1, 1'b0, 8'h1C);
    tick(3);
    check("a_matrix", matrix_dbg, 64'h0020_0000_0000_0000);
    check("a_sense_lat3", 64'(key_sense), 64'd0);
    tick(1);
    check("a_sense_lat4", 64'(key_sense), 64'd1);
    col_mask_n = 8'hFF;
    tick(1);
    check("a_sense_nomask", 64'(key_sense), 64'd0);
    row_sel = 3'd5; col_mask_n = 8'h00;
    tick(1);
    check("a_sense_otherrow", 64'(key_sense), 64'd0);
    send(1'b0, 1'b0, 8'h1C);
    tick(4);
    check("a_release", matrix_dbg, 64'h0);

    // Press then release one cycle apart: the release goes through the pending buffer
    send(1'b1, 1'b0, 8'h1C);
    tick(1);
    send(1'b0, 1'b0, 8'h1C);
    tick(2);
    check("pend_press", matrix_dbg, 64'h0020_0000_0000_0000);
    tick(3);
    check("pend_release", matrix_dbg, 64'h0);

    // A, S, W on consecutive cycles: W overwrites pending S
    send(1'b1, 1'b0, 8'h1C);
    tick(1);
    send(1'b1, 1'b0, 8'h1B);
    tick(1);
    send(1'b1, 1'b0, 8'h1D);
    tick(8);
    check("pend_newest", matrix_dbg, 64'h00A0_0000_0000_0000);
    send(1'b1, 1'b0, 8'h7E);
    tick(4);
    check("clr_after_pend", matrix_dbg, 64'h0);

    // F12: nmi_req high for exactly 16 cycles
    send(1'b1, 1'b0, 8'h07);
    tick(2);
    check("nmi_k2", 64'(nmi_req), 64'd0);
    tick(1);
    check("nmi_k3", 64'(nmi_req), 64'd1);
    tick(15);
    check("nmi_k18", 64'(nmi_req), 64'd1);
    tick(1);
    check("nmi_k19", 64'(nmi_req), 64'd0);
    send(1'b0, 1'b0, 8'h07);
    tick(5);
    check("nmi_release_ign", 64'(nmi_req), 64'd0);
    check("nmi_no_matrix", matrix_dbg, 64'h0);

    // Restart at cycle 10: reload at k=13, high through k=28
    send(1'b1, 1'b0, 8'h07);
    tick(10);
    send(1'b1, 1'b0, 8'h07);
    tick(9);
    check("nmi_re_k19", 64'(nmi_req), 64'd1);
    tick(9);
    check("nmi_re_k28", 64'(nmi_req), 64'd1);
    tick(1);
    check("nmi_re_k29", 64'(nmi_req), 64'd0);

    // Five keys then Scroll Lock
    send(1'b1, 1'b0, 8'h1C); tick(4);
    send(1'b1, 1'b0, 8'h1B); tick(4);
    send(1'b1, 1'b0, 8'h1D); tick(4);
    send(1'b1, 1'b0, 8'h15); tick(4);
    send(1'b1, 1'b0, 8'h29); tick(4);
    check("five_keys", matrix_dbg, 64'h00E0_0001_0000_4000);
    row_sel = 3'd4; col_mask_n = 8'hFE;
    tick(1);
    check("space_sense", 64'(key_sense), 64'd1);
    send(1'b1, 1'b0, 8'h7E);
    tick(3);
    check("scroll_clear", matrix_dbg, 64'h0);
    tick(1);
    check("scroll_sense", 64'(key_sense), 64'd0);

    // Extended vs plain 0x75, unmapped extended, both shifts, idempotence
    send(1'b1, 1'b1, 8'h75); tick(4);
    check("ext75", matrix_dbg, 64'h0000_0008_0000_0000);
    send(1'b0, 1'b1, 8'h75); tick(4);
    send(1'b1, 1'b0, 8'h75); tick(4);
    check("plain75", matrix_dbg, 64'h0100_0000_0000_0000);
    send(1'b1, 1'b1, 8'h1C); tick(4);
    check("unmapped_ext", matrix_dbg, 64'h0100_0000_0000_0000);
    send(1'b1, 1'b0, 8'h59); tick(4);
    send(1'b1, 1'b0, 8'h59); tick(4);
    check("rshift_idem", matrix_dbg, 64'h1100_0000_0000_0000);
    send(1'b0, 1'b0, 8'h12); tick(4);
    check("lshift_rel_idem", matrix_dbg, 64'h1100_0000_0000_0000);
    send(1'b1, 1'b0, 8'h12); tick(4);
    check("lshift", matrix_dbg, 64'h1100_0010_0000_0000);
    send(1'b1, 1'b0, 8'h7E); tick(4);
    check("clear2", matrix_dbg, 64'h0);

    // Reset while in LOOKUP with the pending buffer holding W
    row_sel = 3'd6; col_mask_n = 8'h00;
    send(1'b1, 1'b0, 8'h1C);
    tick(1);
    send(1'b1, 1'b0, 8'h1B);
    tick(2);
    send(1'b1, 1'b0, 8'h1D);
    tick(1);
    check("pre_rst_matrix", matrix_dbg, 64'h0020_0000_0000_0000);
    reset = 1'b1;
    #1;
    check("midrst_matrix", matrix_dbg, 64'h0);
    check("midrst_sense", 64'(key_sense), 64'd0);
    check("midrst_nmi", 64'(nmi_req), 64'd0);
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    tick(3);
    reset = 1'b0;
    tick(8);
    check("post_rst_matrix", matrix_dbg, 64'h0);
    check("post_rst_sense", 64'(key_sense), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
